aes_decryption: RTL and testbench

AES_DECRYPTION -- requirements
Module: aes_decryption

---
 rtl/aes_decryption.sv | 105 ++++++++++
 tb/tb_aes_decryption.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/aes_decryption.sv
// Toy AES-style decryptor: byte-rotate/XOR rounds against rotated copies of a loaded key.
// Latency: AES_ROUNDS+2 rising edges, from the edge that samples next to the edge that raises plaintext_valid.
// Backpressure: none; init/next are accepted only while ready=1 and are ignored while busy.
module aes_decryption #(
  parameter int AES_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         next,
  input  logic [127:0] key,
  input  logic [127:0] ciphertext,
  output logic         ready,
  output logic [127:0] plaintext,
  output logic         plaintext_valid
);

  typedef enum logic {
    IDLE   = 1'b0,
    ROUNDS = 1'b1
  } state_e;

  state_e       fsm_q, fsm_d;
  logic [127:0] key_q, key_d;
  logic         key_loaded_q, key_loaded_d;
  logic [127:0] data_q, data_d;
  logic [5:0]   round_ctr_q, round_ctr_d;
  logic         valid_q, valid_d;

  // Round key i is the key rotated left by 8*i bits; rotation wraps every 16 bytes.
  function automatic logic [127:0] round_key(input logic [127:0] k, input logic [3:0] i);
    logic [6:0]   sh;
    logic [255:0] dbl;
    sh  = {i, 3'b000};
    dbl = {k, k} << sh;
    return dbl[255:128];
  endfunction

  // Rotate the block right by one byte.
  function automatic logic [127:0] rotr8(input logic [127:0] x);
    return {x[7:0], x[127:8]};
  endfunction

  // State registers; reset clears all key and data material immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q        <= IDLE;
      key_q        <= '0;
      key_loaded_q <= 1'b0;
      data_q       <= '0;
      round_ctr_q  <= '0;
      valid_q      <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      key_q        <= key_d;
      key_loaded_q <= key_loaded_d;
      data_q       <= data_d;
      round_ctr_q  <= round_ctr_d;
      valid_q      <= valid_d;
    end
  end

  // Next-state logic: init has priority over next in IDLE; both are ignored during ROUNDS.
  always_comb begin
    fsm_d        = fsm_q;
    key_d        = key_q;
    key_loaded_d = key_loaded_q;
    data_d       = data_q;
    round_ctr_d  = round_ctr_q;
    valid_d      = valid_q;
    case (fsm_q)
      IDLE: begin
        if (init) begin
          key_d        = key;
          key_loaded_d = 1'b1;
          data_d       = '0;
          valid_d      = 1'b0;
        end else if (next && key_loaded_q) begin
          data_d      = ciphertext;
          round_ctr_d = 6'(AES_ROUNDS);
          valid_d     = 1'b0;
          fsm_d       = ROUNDS;
        end
      end
      ROUNDS: begin
        if (round_ctr_q != 6'd0) begin
          data_d      = rotr8(data_q) ^ round_key(key_q, round_ctr_q[3:0]);
          round_ctr_d = round_ctr_q - 6'd1;
        end else begin
          // Final whitening with the unrotated key.
          data_d  = data_q ^ key_q;
          valid_d = 1'b1;
          fsm_d   = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Intermediate round state is masked off the output until the result is complete.
  assign ready           = (fsm_q == IDLE);
  assign plaintext_valid = valid_q;
  assign plaintext       = data_q & {128{valid_q}};

endmodule

// File: tb/tb_aes_decryption.sv
// Self-checking bench for aes_decryption against a byte-array reference model.
// Latency: checks the AES_ROUNDS+2 edge result latency on every decryption.
// Backpressure: none; exercises ignored init/next while busy and without a key.
module tb_aes_decryption;

  localparam int ROUNDS = 10;
  localparam int LAT    = ROUNDS + 2;

  logic         clk;
  logic         rst;
  logic         init;
  logic         next;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic         ready;
  logic [127:0] plaintext;
  logic         plaintext_valid;

  int n_vec;
  int n_err;

  aes_decryption #(.AES_ROUNDS(ROUNDS)) dut (
    .clk            (clk),
    .rst            (rst),
    .init           (init),
    .next           (next),
    .key            (key),
    .ciphertext     (ciphertext),
    .ready          (ready),
    .plaintext      (plaintext),
    .plaintext_valid(plaintext_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: ciphertext as 16 bytes (byte 0 = MSB); each round rotates the bytes
  // right by one and XORs the key viewed with a byte offset of r.
  function automatic logic [127:0] ref_decrypt(input logic [127:0] k, input logic [127:0] c);
    byte unsigned s [16];
    byte unsigned kb[16];
    byte unsigned t [16];
    logic [127:0] res;
    for (int j = 0; j < 16; j++) begin
      s[j]  = c[127-8*j -: 8];
      kb[j] = k[127-8*j -: 8];
    end
    for (int r = ROUNDS; r >= 1; r--) begin
      for (int j = 0; j < 16; j++) t[j] = s[(j+15)%16] ^ kb[(j+r)%16];
      s = t;
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j] ^ kb[j];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic do_init(input logic [127:0] k);
    @(negedge clk);
    init = 1'b1;
    key  = k;
    @(posedge clk); #1;
    init = 1'b0;
  endtask

  // Pulse next; returns #1 after the sampling edge.
  task automatic start_next(input logic [127:0] c);
    @(negedge clk);
    next       = 1'b1;
    ciphertext = c;
    @(posedge clk); #1;
    next = 1'b0;
  endtask

  // Counts edges from the sampling edge until valid; optionally injects
  // init/next while busy to confirm they are ignored.
  task automatic wait_result(input string tag, input logic [127:0] exp, input bit inject);
    int n;
    n = 1;
    chk({tag, "_busy"}, {127'b0, ready}, 128'd0);
    while (!plaintext_valid && n < 40) begin
      if (inject && n == 3) begin
        init = 1'b1; next = 1'b1; key = rand128(); ciphertext = rand128();
      end else begin
        init = 1'b0; next = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    init = 1'b0; next = 1'b0;
    chk({tag, "_lat"}, 128'(n), 128'(LAT));
    chk({tag, "_rdy"}, {127'b0, ready}, 128'd1);
    chk({tag, "_pt"}, plaintext, exp);
  endtask

  logic [127:0] k_cur, c_cur, exp_pt;

  initial begin
    n_vec = 0; n_err = 0;
    init = 1'b0; next = 1'b0; key = '0; ciphertext = '0;
    rst = 1'b0;
    #12;
    chk("rst_ready", {127'b0, ready}, 128'd1);
    chk("rst_valid", {127'b0, plaintext_valid}, 128'd0);
    chk("rst_pt", plaintext, 128'd0);
    @(negedge clk); rst = 1'b1;

    // No key loaded: next ignored.
    start_next(rand128());
    for (int i = 0; i < 20; i++) begin
      chk("nokey_ready", {127'b0, ready}, 128'd1);
      chk("nokey_valid", {127'b0, plaintext_valid}, 128'd0);
      chk("nokey_pt", plaintext, 128'd0);
      @(posedge clk); #1;
    end

    // Key-zero vector.
    do_init(128'd0);
    start_next(128'h000102030405060708090a0b0c0d0e0f);
    wait_result("kzero", 128'h060708090a0b0c0d0e0f000102030405, 1'b0);

    // Result holds while idle.
    repeat (5) @(posedge clk); #1;
    chk("hold_pt", plaintext, 128'h060708090a0b0c0d0e0f000102030405);
    chk("hold_valid", {127'b0, plaintext_valid}, 128'd1);

    // Key-ones vector.
    do_init({128{1'b1}});
    start_next(128'd0);
    wait_result("kones", {128{1'b1}}, 1'b0);

    // Busy-ignore: init/next during ROUNDS do not disturb the result or key.
    do_init(128'd0);
    start_next(128'h000102030405060708090a0b0c0d0e0f);
    wait_result("busy", 128'h060708090a0b0c0d0e0f000102030405, 1'b1);
    start_next(128'h000102030405060708090a0b0c0d0e0f);
    wait_result("busy_key", 128'h060708090a0b0c0d0e0f000102030405, 1'b0);

    // Simultaneous init/next: init wins, no decryption starts.
    k_cur = rand128();
    @(negedge clk);
    init = 1'b1; next = 1'b1; key = k_cur; ciphertext = rand128();
    @(posedge clk); #1;
    init = 1'b0; next = 1'b0;
    chk("sim_ready", {127'b0, ready}, 128'd1);
    chk("sim_valid", {127'b0, plaintext_valid}, 128'd0);
    chk("sim_pt", plaintext, 128'd0);
    @(posedge clk); #1;
    chk("sim_ready2", {127'b0, ready}, 128'd1);
    c_cur = rand128();
    start_next(c_cur);
    wait_result("sim_newkey", ref_decrypt(k_cur, c_cur), 1'b0);

    // Randomized keys and blocks.
    for (int i = 0; i < 16; i++) begin
      if (i % 3 == 0) begin
        k_cur = rand128();
        do_init(k_cur);
        chk("rnd_initclr", plaintext, 128'd0);
      end
      c_cur  = rand128();
      exp_pt = ref_decrypt(k_cur, c_cur);
      start_next(c_cur);
      wait_result("rnd", exp_pt, 1'b0);
    end

    // Mid-op reset at round_ctr = 5: outputs clear at once, key is forgotten.
    start_next(rand128());
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mrst_ready", {127'b0, ready}, 128'd1);
    chk("mrst_valid", {127'b0, plaintext_valid}, 128'd0);
    chk("mrst_pt", plaintext, 128'd0);
    @(negedge clk); rst = 1'b1;
    start_next(rand128());
    for (int i = 0; i < 20; i++) begin
      chk("mrst_nokey_ready", {127'b0, ready}, 128'd1);
      chk("mrst_nokey_valid", {127'b0, plaintext_valid}, 128'd0);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
